// File: rtl/definitions_pkg.sv
// Shared pipeline definitions for the fetch stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package definitions_pkg;

  typedef enum logic [1:0] {
    FS_REQ   = 2'd0,  // request valid, waiting for imem_req_ready
    FS_WAIT  = 2'd1,  // request accepted, response pending
    FS_FLUSH = 2'd2,  // pending response is stale and will be dropped
    FS_HOLD  = 2'd3   // response parked in skid buffer, output occupied
  } fetch_state_e;

  localparam logic [31:0] NOP_INST   = 32'h0000_0013;
  localparam logic [31:0] INST_BYTES = 32'd4;

  // Word-align a byte address by clearing the two low bits.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Single-entry instruction+PC holding register for the fetch stage.
// Latency: loaded value visible the cycle after load.
// Backpressure: none of its own; clear beats load beats unload.
// Ports: load/unload/clear controls, in_inst/in_pc data in,
//        buf_valid/buf_inst/buf_pc stored entry out.
module fetch_skid_buf
  import definitions_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        unload,
  input  logic        clear,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  output logic        buf_valid,
  output logic [31:0] buf_inst,
  output logic [31:0] buf_pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      buf_inst  <= NOP_INST;
      buf_pc    <= '0;
    end else if (clear) begin
      buf_valid <= 1'b0;
    end else if (load) begin
      buf_valid <= 1'b1;
      buf_inst  <= in_inst;
      buf_pc    <= in_pc;
    end else if (unload) begin
      buf_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, fetches from imem, presents inst+pc to decode.
// Latency: request accepted in N, response N+1 earliest, if_valid in N+2.
// Backpressure: id_ready low holds the output; one extra response parks in the skid buffer.
// Ports: imem_req_* (valid/ready request), imem_resp_* (valid-only response),
//        redirect_* (PC change, highest priority), id_ready/if_* (decode handshake).
module if_stage
  import definitions_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  infl_pc;     // address of the request currently in flight
  logic         out_free;
  logic         skid_load;
  logic         skid_unload;
  logic         skid_vld;
  logic [31:0]  skid_inst;
  logic [31:0]  skid_pc;

  assign imem_req_valid = (state == FS_REQ);
  assign imem_req_addr  = pc;
  assign out_free       = !if_valid || id_ready;

  assign skid_load   = !redirect_valid && (state == FS_WAIT) && imem_resp_valid && !out_free;
  assign skid_unload = !redirect_valid && (state == FS_HOLD) && id_ready;

  fetch_skid_buf u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (skid_load),
    .unload    (skid_unload),
    .clear     (redirect_valid),
    .in_inst   (imem_resp_data),
    .in_pc     (infl_pc),
    .buf_valid (skid_vld),
    .buf_inst  (skid_inst),
    .buf_pc    (skid_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FS_REQ;
      pc       <= RESET_PC;
      infl_pc  <= RESET_PC;
      if_valid <= 1'b0;
      if_inst  <= NOP_INST;
      if_pc    <= RESET_PC;
    end else if (redirect_valid) begin
      // Any output transfer this cycle still completes; everything
      // younger than the redirect is dropped.
      pc       <= align_pc(redirect_pc);
      if_valid <= 1'b0;
      case (state)
        FS_REQ:   state <= imem_req_ready ? FS_FLUSH : FS_REQ;
        FS_WAIT:  state <= imem_resp_valid ? FS_REQ : FS_FLUSH;
        // The stale response may land in the same cycle as a second
        // redirect; it is dropped either way, so leave FLUSH rather than
        // waiting forever for a response that will never come.
        FS_FLUSH: state <= imem_resp_valid ? FS_REQ : FS_FLUSH;
        FS_HOLD:  state <= FS_REQ;
        default:  state <= FS_REQ;
      endcase
    end else begin
      // Default: a completed transfer empties the output; loads below override.
      if (if_valid && id_ready) begin
        if_valid <= 1'b0;
      end
      case (state)
        FS_REQ: begin
          if (imem_req_ready) begin
            infl_pc <= pc;
            pc      <= pc + INST_BYTES;
            state   <= FS_WAIT;
          end
        end
        FS_WAIT: begin
          if (imem_resp_valid) begin
            if (out_free) begin
              if_inst  <= imem_resp_data;
              if_pc    <= infl_pc;
              if_valid <= 1'b1;
              state    <= FS_REQ;
            end else begin
              state <= FS_HOLD;
            end
          end
        end
        FS_FLUSH: begin
          if (imem_resp_valid) begin
            state <= FS_REQ;
          end
        end
        FS_HOLD: begin
          if (id_ready && skid_vld) begin
            if_inst  <= skid_inst;
            if_pc    <= skid_pc;
            if_valid <= 1'b1;
            state    <= FS_REQ;
          end
        end
        default: state <= FS_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // Main DUT (RESET_PC = 0)
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_inst, if_pc;

  // Wrap DUT (RESET_PC near the top of the address space)
  logic        req_valid_w, req_ready_w;
  logic [31:0] req_addr_w;
  logic        resp_valid_w;
  logic [31:0] resp_data_w;
  logic        id_ready_w;
  logic        if_valid_w;
  logic [31:0] if_inst_w, if_pc_w;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(req_valid_w), .imem_req_ready(req_ready_w),
    .imem_req_addr(req_addr_w),
    .imem_resp_valid(resp_valid_w), .imem_resp_data(resp_data_w),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .id_ready(id_ready_w),
    .if_valid(if_valid_w), .if_inst(if_inst_w), .if_pc(if_pc_w)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a memory that answers one request after `lat` cycles,
  // and the program-order expectation for requests and deliveries.
  logic        pend;
  logic [31:0] pend_addr;
  int          cnt;
  logic [31:0] exp_pc, exp_req, last_pc;
  int          n_xfer;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input logic [31:0] rpc);
    pend    = 1'b0;
    cnt     = 0;
    exp_pc  = rpc;
    exp_req = rpc;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input logic rr, input logic idr, input logic rv,
                      input logic [31:0] rpc, input int lat);
    logic        hold, drv;
    logic [31:0] hp, hi;
    check("no_req_while_pending", {31'b0, imem_req_valid && pend}, 32'd0);
    drv             = pend && (cnt == 0);
    imem_resp_valid = drv;
    imem_resp_data  = drv ? mem(pend_addr) : 32'hDEAD_BEEF;
    imem_req_ready  = rr && !pend;
    id_ready        = idr;
    redirect_valid  = rv;
    redirect_pc     = rpc;
    hold = if_valid && !idr && !rv;
    hp   = if_pc;
    hi   = if_inst;
    if (if_valid && idr) begin
      check("xfer_pc", if_pc, exp_pc);
      check("xfer_inst", if_inst, mem(exp_pc));
      last_pc = if_pc;
      exp_pc  = exp_pc + 32'd4;
      n_xfer++;
    end
    if (drv) pend = 1'b0;
    else if (pend) cnt--;
    if (imem_req_valid && imem_req_ready) begin
      check("req_addr", imem_req_addr, exp_req);
      exp_req   = exp_req + 32'd4;
      pend      = 1'b1;
      pend_addr = imem_req_addr;
      cnt       = lat - 1;
    end
    if (rv) begin
      exp_pc  = rpc & 32'hFFFF_FFFC;
      exp_req = rpc & 32'hFFFF_FFFC;
    end
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      check("hold_valid", {31'b0, if_valid}, 32'd1);
      check("hold_pc", if_pc, hp);
      check("hold_inst", if_inst, hi);
    end
  endtask

  initial begin
    logic        found;
    int          n0;
    logic        p2;
    logic [31:0] a2;
    logic [31:0] acc_q[$];
    logic [31:0] dlv_q[$];

    rst_n = 1'b0;
    imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = 0;
    redirect_valid = 0; redirect_pc = 0; id_ready = 0;
    req_ready_w = 0; resp_valid_w = 0; resp_data_w = 0; id_ready_w = 0;
    n_xfer = 0; last_pc = 32'hFFFF_FFFF; pend_addr = 0;
    model_reset(32'h0);

    // ---- Reset values
    #12;
    check("rst_if_valid", {31'b0, if_valid}, 32'd0);
    check("rst_if_inst", if_inst, 32'h0000_0013);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd1);
    @(negedge clk);

    // ---- Free-running fetch: if_valid pulses every second cycle from cycle 2
    for (int i = 0; i < 8; i++) begin
      check("free_if_valid", {31'b0, if_valid}, {31'b0, (i >= 2) && (i % 2 == 0)});
      step(1'b1, 1'b1, 1'b0, 32'h0, 1);
    end
    check("free_last_pc", last_pc, 32'h8);

    // ---- Decode stall: output holds, next response parks, no requests
    for (int i = 0; i < 6; i++) begin
      if (i >= 2) check("stall_no_req", {31'b0, imem_req_valid}, 32'd0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1);
    end
    check("release_valid0", {31'b0, if_valid}, 32'd1);
    check("release_pc0", if_pc, 32'hC);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1);
    check("release_valid1", {31'b0, if_valid}, 32'd1);
    check("release_pc1", if_pc, 32'h10);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1);

    // ---- Redirect in FS_WAIT with no response
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (imem_req_valid && !pend) found = 1'b1;
      else step(1'b1, 1'b1, 1'b0, 32'h0, 1);
    end
    check("reach_req", {31'b0, found}, 32'd1);
    step(1'b1, 1'b1, 1'b0, 32'h0, 3);           // accept, slow response
    step(1'b1, 1'b1, 1'b1, 32'h0000_0102, 1);   // redirect while waiting
    check("flush_no_req0", {31'b0, imem_req_valid}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1);
    check("flush_no_req1", {31'b0, imem_req_valid}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1);           // stale response consumed
    check("redir_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("redir_req_addr", imem_req_addr, 32'h100);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1);
    check("redir_delivered", last_pc, 32'h100);

    // ---- Redirect in the same cycle as a response
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pend && cnt == 0) begin
        step(1'b1, 1'b1, 1'b1, 32'h0000_0200, 1);
        found = 1'b1;
      end else begin
        step(1'b1, 1'b1, 1'b0, 32'h0, 1);
      end
    end
    check("reach_resp", {31'b0, found}, 32'd1);
    check("drop_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("drop_req_addr", imem_req_addr, 32'h200);
    check("drop_if_valid", {31'b0, if_valid}, 32'd0);

    // ---- Randomized traffic with redirects
    n0 = n_xfer;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0, $urandom, $urandom_range(1, 3));
    end
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1);
    check("random_progress", {31'b0, n_xfer > n0 + 20}, 32'd1);

    // ---- Asynchronous reset while in FS_HOLD
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (!imem_req_valid && !pend && if_valid) found = 1'b1;
      else step(1'b1, 1'b0, 1'b0, 32'h0, 1);
    end
    check("reach_hold", {31'b0, found}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_if_valid", {31'b0, if_valid}, 32'd0);
    check("arst_if_inst", if_inst, 32'h0000_0013);
    check("arst_if_pc", if_pc, 32'h0);
    check("arst_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("arst_req_addr", imem_req_addr, 32'h0);
    @(negedge clk);
    model_reset(32'h0);
    rst_n = 1'b1;
    check("post_rst_addr", imem_req_addr, 32'h0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1);
    check("post_rst_delivered", last_pc, 32'h4);

    // ---- PC wrap on the second instance
    imem_req_ready = 0; id_ready = 0; redirect_valid = 0; imem_resp_valid = 0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    p2 = 1'b0;
    a2 = 32'h0;
    for (int i = 0; i < 10; i++) begin
      resp_valid_w = p2;
      resp_data_w  = mem(a2);
      req_ready_w  = !p2;
      id_ready_w   = 1'b1;
      if (if_valid_w) begin
        dlv_q.push_back(if_pc_w);
        check("wrap_inst", if_inst_w, mem(if_pc_w));
      end
      if (req_valid_w && req_ready_w) begin
        acc_q.push_back(req_addr_w);
        a2 = req_addr_w;
        p2 = 1'b1;
      end else begin
        p2 = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    check("wrap_n_req", {31'b0, acc_q.size() >= 3}, 32'd1);
    check("wrap_n_dlv", {31'b0, dlv_q.size() >= 3}, 32'd1);
    if (acc_q.size() >= 3) begin
      check("wrap_req0", acc_q[0], 32'hFFFF_FFF8);
      check("wrap_req1", acc_q[1], 32'hFFFF_FFFC);
      check("wrap_req2", acc_q[2], 32'h0000_0000);
    end
    if (dlv_q.size() >= 3) begin
      check("wrap_dlv0", dlv_q[0], 32'hFFFF_FFF8);
      check("wrap_dlv1", dlv_q[1], 32'hFFFF_FFFC);
      check("wrap_dlv2", dlv_q[2], 32'h0000_0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
